// File: rtl/finv.sv
`default_nettype none
// ============================================================================
// finv : two-stage pipelined IEEE-754 single-precision reciprocal using a
//        piecewise-linear mantissa table.     Rev 1.0
// ============================================================================
module finv #(
  parameter int TBL_BITS = 10
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] src,
  output logic [31:0] dest,
  output logic        ovf,
  output logic        udf
);

  localparam int c_tbl_n    = 1 << TBL_BITS;
  localparam int c_lo_bits  = 23 - TBL_BITS;
  localparam int c_icpt_w   = 32;                 // value scaled by 2^32
  localparam int c_slope_w  = 16;                 // value scaled by 2^16
  localparam int c_prod_w   = c_slope_w + c_lo_bits;
  localparam int c_align_sh = 16 + 23 - 32;

  localparam logic [2:0] c_cls_norm = 3'd0;
  localparam logic [2:0] c_cls_zero = 3'd1;
  localparam logic [2:0] c_cls_udf  = 3'd2;
  localparam logic [2:0] c_cls_inf  = 3'd3;
  localparam logic [2:0] c_cls_nan  = 3'd4;

  // Chord of 1/x across the interval, lowered by half its peak sag so the
  // error is split evenly above and below the curve.
  function automatic logic [31:0] calc_icpt(input longint unsigned idx);
    longint unsigned n, ni, one, base, half_gap;
    n        = 64'(c_tbl_n);
    ni       = n + idx;
    one      = 64'd1 << 32;
    base     = (one * n + ni / 64'd2) / ni;
    half_gap = (one * n) / (64'd4 * ni * (ni + 64'd1) * (64'd2 * ni + 64'd1));
    return 32'(base - half_gap);
  endfunction

  function automatic logic [15:0] calc_slope(input longint unsigned idx);
    longint unsigned n, ni, den;
    n   = 64'(c_tbl_n);
    ni  = n + idx;
    den = ni * (ni + 64'd1);
    return 16'((((n * n) << 16) + den / 64'd2) / den);
  endfunction

  logic [c_icpt_w-1:0]  w_icpt_tbl  [c_tbl_n];
  logic [c_slope_w-1:0] w_slope_tbl [c_tbl_n];

  for (genvar gi = 0; gi < c_tbl_n; gi++) begin : g_tbl
    localparam logic [c_icpt_w-1:0]  c_icpt  = calc_icpt(64'(gi));
    localparam logic [c_slope_w-1:0] c_slope = calc_slope(64'(gi));
    assign w_icpt_tbl[gi]  = c_icpt;
    assign w_slope_tbl[gi] = c_slope;
  end

  // Stage 1: decode and table lookup
  logic                 w_sign;
  logic [7:0]           w_exp;
  logic [22:0]          w_man;
  logic                 w_mzero;
  logic [TBL_BITS-1:0]  w_idx;
  logic [c_lo_bits-1:0] w_lo;
  logic [2:0]           w_cls;
  logic [7:0]           w_rexp;

  assign w_sign  = src[31];
  assign w_exp   = src[30:23];
  assign w_man   = src[22:0];
  assign w_mzero = (w_man == 23'd0);
  assign w_idx   = w_man[22 -: TBL_BITS];
  assign w_lo    = w_man[c_lo_bits-1:0];

  always_comb begin
    w_cls  = c_cls_norm;
    w_rexp = 8'd0;
    if (w_exp == 8'hFF) begin
      w_cls = w_mzero ? c_cls_inf : c_cls_nan;
    end else if (w_exp == 8'd0) begin
      w_cls = c_cls_zero;
    end else if (w_mzero) begin
      if (w_exp >= 8'd254) w_cls = c_cls_udf;
      else                 w_rexp = 8'd254 - w_exp;
    end else begin
      if (w_exp >= 8'd253) w_cls = c_cls_udf;
      else                 w_rexp = 8'd253 - w_exp;
    end
  end

  logic                 r_sign;
  logic [2:0]           r_cls;
  logic [7:0]           r_exp;
  logic                 r_mzero;
  logic [c_icpt_w-1:0]  r_icpt;
  logic [c_slope_w-1:0] r_slope;
  logic [c_lo_bits-1:0] r_lo;

  // Reset state (normal class, exp 0, exact) drains through stage 2 as +0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sign  <= 1'b0;
      r_cls   <= c_cls_norm;
      r_exp   <= 8'd0;
      r_mzero <= 1'b1;
      r_icpt  <= '0;
      r_slope <= '0;
      r_lo    <= '0;
    end else begin
      r_sign  <= w_sign;
      r_cls   <= w_cls;
      r_exp   <= w_rexp;
      r_mzero <= w_mzero;
      r_icpt  <= w_icpt_tbl[w_idx];
      r_slope <= w_slope_tbl[w_idx];
      r_lo    <= w_lo;
    end
  end

  // Stage 2: y = intercept - slope*t, y in (0.5, 1) for a non-zero mantissa
  logic [c_prod_w-1:0] w_prod;
  logic [31:0]         w_corr;
  logic [31:0]         w_y;
  logic [24:0]         w_ysh;
  logic [23:0]         w_rnd;
  logic [22:0]         w_frac;

  assign w_prod = c_prod_w'(r_slope) * c_prod_w'(r_lo);
  assign w_corr = 32'(w_prod >> c_align_sh);
  assign w_y    = r_icpt - w_corr;
  assign w_ysh  = 25'(w_y >> 7);
  assign w_rnd  = {1'b0, w_ysh[23:1]} + {23'd0, w_ysh[0]};
  // Normalised mantissa is 2y; saturate rather than let rounding wrap.
  assign w_frac = !w_ysh[24] ? 23'd0 : (w_rnd[23] ? '1 : w_rnd[22:0]);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dest <= 32'd0;
      ovf  <= 1'b0;
      udf  <= 1'b0;
    end else begin
      ovf <= 1'b0;
      udf <= 1'b0;
      case (r_cls)
        c_cls_zero: begin
          dest <= {r_sign, 8'hFF, 23'd0};
          ovf  <= 1'b1;
        end
        c_cls_udf: begin
          dest <= {r_sign, 31'd0};
          udf  <= 1'b1;
        end
        c_cls_inf:  dest <= {r_sign, 31'd0};
        c_cls_nan:  dest <= 32'h7FC00000;
        default:    dest <= {r_sign, r_exp, (r_mzero ? 23'd0 : w_frac)};
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_finv.sv
`default_nettype none
// Testbench for finv: directed vector table, random back-to-back stream
// against a real-arithmetic model, and an in-flight asynchronous reset.
module tb_finv;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] src;
  logic [31:0] dest;
  logic        ovf;
  logic        udf;

  finv #(.TBL_BITS(10)) dut (
    .clk  (clk),
    .rstn (rstn),
    .src  (src),
    .dest (dest),
    .ovf  (ovf),
    .udf  (udf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] src;
    logic [31:0] dest;
    logic        ovf;
    logic        udf;
    int          tol;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic vec_t mk(input logic [31:0] s, input logic [31:0] d,
                              input logic o, input logic u, input int t);
    vec_t v;
    v.src = s; v.dest = d; v.ovf = o; v.udf = u; v.tol = t;
    return v;
  endfunction

  // Reference: class rules plus a real-valued 1/x rounded to nearest.
  function automatic vec_t model(input logic [31:0] x);
    vec_t        v;
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
    logic [63:0] db, rb;
    real         rr;
    int          fe;
    logic [23:0] fm;
    s = x[31]; e = x[30:23]; m = x[22:0];
    v = mk(x, 32'd0, 1'b0, 1'b0, 0);
    if (e == 8'hFF) begin
      v.dest = (m == 23'd0) ? {s, 31'd0} : 32'h7FC00000;
    end else if (e == 8'd0) begin
      v.dest = {s, 8'hFF, 23'd0};
      v.ovf  = 1'b1;
    end else if (m == 23'd0) begin
      if (e >= 8'd254) begin v.dest = {s, 31'd0}; v.udf = 1'b1; end
      else v.dest = {s, 8'(8'd254 - e), 23'd0};
    end else if (e >= 8'd253) begin
      v.dest = {s, 31'd0};
      v.udf  = 1'b1;
    end else begin
      db = {s, 11'(int'(e) + 896), m, 29'd0};
      rr = 1.0 / $bitstoreal(db);
      rb = $realtobits(rr);
      fe = int'(rb[62:52]) - 896;
      fm = {1'b0, rb[51:29]} + {23'd0, rb[28]};
      if (fm[23]) fe = fe + 1;
      v.dest = {s, 8'(fe), fm[22:0]};
      v.tol  = 4;
    end
    return v;
  endfunction

  task automatic check_res(input string name, input vec_t v);
    int a, b, d;
    a = int'({1'b0, dest[30:0]});
    b = int'({1'b0, v.dest[30:0]});
    d = (a > b) ? a - b : b - a;
    n_checks++;
    if (dest[31] != v.dest[31] || d > v.tol) begin
      n_fail++;
      $display("FAIL %s dest (src %h): got %h, expected %h within %0d ulp",
               name, v.src, dest, v.dest, v.tol);
    end
    n_checks++;
    if (ovf !== v.ovf || udf !== v.udf) begin
      n_fail++;
      $display("FAIL %s flags (src %h): got ovf=%b udf=%b, expected ovf=%b udf=%b",
               name, v.src, ovf, udf, v.ovf, v.udf);
    end
  endtask

  task automatic check_exact(input string name, input logic [31:0] d,
                             input logic o, input logic u);
    n_checks++;
    if (dest !== d || ovf !== o || udf !== u) begin
      n_fail++;
      $display("FAIL %s: got dest=%h ovf=%b udf=%b, expected dest=%h ovf=%b udf=%b",
               name, dest, ovf, udf, d, o, u);
    end
  endtask

  vec_t tbl[$];
  vec_t rq[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    tbl.push_back(mk(32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 0)); // 1.0
    tbl.push_back(mk(32'hC0000000, 32'hBF000000, 1'b0, 1'b0, 0)); // -2.0
    tbl.push_back(mk(32'h40400000, 32'h3EAAAAAB, 1'b0, 1'b0, 4)); // 3.0
    tbl.push_back(mk(32'h00000000, 32'h7F800000, 1'b1, 1'b0, 0)); // +0
    tbl.push_back(mk(32'h80000001, 32'hFF800000, 1'b1, 1'b0, 0)); // -denormal
    tbl.push_back(mk(32'h7F000000, 32'h00000000, 1'b0, 1'b1, 0)); // 2^127
    tbl.push_back(mk(32'h7F800000, 32'h00000000, 1'b0, 1'b0, 0)); // +inf
    tbl.push_back(mk(32'hFF800000, 32'h80000000, 1'b0, 1'b0, 0)); // -inf
    tbl.push_back(mk(32'h7FC00001, 32'h7FC00000, 1'b0, 1'b0, 0)); // NaN
    tbl.push_back(mk(32'hFFFFFFFF, 32'h7FC00000, 1'b0, 1'b0, 0)); // -NaN
    tbl.push_back(mk(32'h3F000000, 32'h40000000, 1'b0, 1'b0, 0)); // 0.5
    tbl.push_back(mk(32'h7E800000, 32'h00800000, 1'b0, 1'b0, 0)); // e=253, m=0
    tbl.push_back(mk(32'h7E800001, 32'h00000000, 1'b0, 1'b1, 0)); // e=253, m!=0
    tbl.push_back(mk(32'hFF7FFFFF, 32'h80000000, 1'b0, 1'b1, 0)); // e=254
    tbl.push_back(mk(32'hFE7FFFFF, 32'h80800001, 1'b0, 1'b0, 4)); // e=252 max m
    tbl.push_back(mk(32'h40A00000, 32'h3E4CCCCD, 1'b0, 1'b0, 4)); // 5.0
    tbl.push_back(mk(32'h3FC00000, 32'h3F2AAAAB, 1'b0, 1'b0, 4)); // 1.5
    tbl.push_back(mk(32'h40E00000, 32'h3E124925, 1'b0, 1'b0, 4)); // 7.0
    for (int k = 0; k < 120; k++) rq.push_back(model($urandom()));

    rstn = 1'b0;
    src  = 32'h3F800000;
    @(posedge clk);
    @(negedge clk);
    check_exact("reset_state", 32'd0, 1'b0, 1'b0);
    rstn = 1'b1;

    // Directed table, issued back-to-back; each result checked 2 edges later.
    for (int i = 0; i < tbl.size() + 2; i++) begin
      if (i > 0) @(negedge clk);
      if (i >= 2) check_res($sformatf("tbl%0d", i - 2), tbl[i - 2]);
      if (i < tbl.size()) src = tbl[i].src;
    end

    for (int i = 0; i < rq.size() + 2; i++) begin
      @(negedge clk);
      if (i >= 2) check_res($sformatf("rand%0d", i - 2), rq[i - 2]);
      if (i < rq.size()) src = rq[i].src;
    end

    // Reset with two results in flight: clears at once, nothing leaks out.
    @(negedge clk) src = 32'h00000000;
    @(negedge clk) src = 32'h3F800000;
    @(posedge clk);
    #2;
    check_exact("inflight_before_reset", 32'h7F800000, 1'b1, 1'b0);
    rstn = 1'b0;
    #1;
    check_exact("async_reset_clear", 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    check_exact("reset_held", 32'd0, 1'b0, 1'b0);
    rstn = 1'b1;
    src  = 32'h40000000;
    @(negedge clk);
    check_exact("no_partial_after_release", 32'd0, 1'b0, 1'b0);
    src = 32'hC0800000;
    @(negedge clk);
    check_exact("resume_first", 32'h3F000000, 1'b0, 1'b0);
    @(negedge clk);
    check_exact("resume_second", 32'hBE800000, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/finv.md
FINV -- requirements
Module: finv

Interface
REQ-001 Parameter: TBL_BITS, default 10, number of mantissa MSBs used to index the approximation table (2^TBL_BITS entries).
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rstn  input  1  asynchronous, active-low reset.
REQ-004 Port: src  input  32  IEEE-754 single-precision operand x.
REQ-005 Port: dest  output  32  registered IEEE-754 single-precision result 1/x.
REQ-006 Port: ovf  output  1  registered overflow flag, aligned with dest.
REQ-007 Port: udf  output  1  registered underflow flag, aligned with dest.

Function
REQ-008 The module SHALL compute dest = 1/src with a latency of exactly 2 rising clk edges: src sampled at edge N, result on dest/ovf/udf after edge N+1 and stable until edge N+2.
REQ-009 The module SHALL be fully pipelined and accept a new src every cycle without stalls; there is no handshake.
REQ-010 Stage 1 SHALL decode sign s, exponent e and mantissa m, look up the slope and intercept for the mantissa interval selected by the top TBL_BITS bits of m, and register them with the low mantissa bits and the special-case class.
REQ-011 Stage 2 SHALL evaluate intercept minus slope times the low mantissa bits, normalise, assemble sign/exponent/mantissa, and register dest, ovf and udf.
REQ-012 Table contents SHALL be constants fixed at elaboration; no external memory initialisation file.
REQ-013 Result sign SHALL equal the src sign in every case except NaN.
REQ-014 For normal src with m == 0, the result SHALL be exact: exponent 254-e, mantissa 0.
REQ-015 For normal src with m != 0, the result exponent SHALL be 253-e, and the result SHALL be within 4 ulp of the correctly rounded IEEE quotient 1.0/src.
REQ-016 Zero or denormal src (e == 0) SHALL be treated as zero: dest = signed infinity (s,0xFF,0), ovf = 1, udf = 0.
REQ-017 When the computed result exponent is <= 0 (e >= 254 with m == 0, or e >= 253 with m != 0), dest SHALL be signed zero, udf = 1, ovf = 0; no denormal output is produced.
REQ-018 Infinite src (e == 0xFF, m == 0) SHALL give signed zero with ovf = 0 and udf = 0.
REQ-019 NaN src (e == 0xFF, m != 0) SHALL give 0x7FC00000 with ovf = 0 and udf = 0.
REQ-020 In all other cases ovf and udf SHALL be 0; at most one of them is 1 in any cycle.

Reset
REQ-021 While rstn is low, all pipeline registers SHALL clear asynchronously, so dest = 0x00000000, ovf = 0, udf = 0.
REQ-022 After rstn deasserts, the first valid result SHALL appear 2 edges after the first sampled src; outputs before that are the reset values or pipeline contents derived from sampled inputs.
REQ-023 A reset asserted mid-operation SHALL discard all in-flight results; no partial result appears after release.

Verification
REQ-024 src 0x3F800000 (1.0) -> dest 0x3F800000 two edges later, ovf = 0, udf = 0.
REQ-025 src 0xC0000000 (-2.0) -> dest 0xBF000000 exactly; src 0x40400000 (3.0) -> dest within 4 ulp of 0x3EAAAAAB.
REQ-026 src 0x00000000 -> dest 0x7F800000, ovf = 1; src 0x80000001 -> dest 0xFF800000, ovf = 1.
REQ-027 src 0x7F000000 (2^127) -> dest 0x00000000, udf = 1; src 0x7F800000 -> 0x00000000 with no flags; src 0x7FC00001 -> 0x7FC00000.
REQ-028 Random 32-bit src for at least 100 vectors, one per cycle back-to-back -> each dest matches the REQ-013..020 model within 4 ulp, and is correctly aligned 2 edges after its src.
REQ-029 rstn pulsed low while 2 results are in flight -> dest = 0, ovf = 0, udf = 0 immediately, without waiting for a clock edge; correct results resume 2 edges after new inputs.
